// File: rtl/matrix_pkg.sv
// Shared sizing constants and FSM state type for the matrix subtract sequencer.
package matrix_pkg;

  localparam int unsigned N     = 5;
  localparam int unsigned W     = 8;
  localparam int unsigned MAT_W = N * N * W;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/elem_subtractor.sv
// Single W-bit two's-complement subtractor with signed-overflow detection.
module elem_subtractor
  import matrix_pkg::*;
#(
  parameter int unsigned W = matrix_pkg::W
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_diff,
  output logic         o_ovf
);

  // Difference wraps modulo 2^W; overflow when operand signs differ and the
  // result sign disagrees with the minuend.
  always_comb begin
    o_diff = i_a - i_b;
    o_ovf  = (i_a[W-1] != i_b[W-1]) && (o_diff[W-1] != i_a[W-1]);
  end

endmodule

// File: rtl/matrix_sub_sequencer.sv
// Element-serial matrix subtractor: captures A and B, then computes A-B one
// element per cycle through a single shared subtractor.
module matrix_sub_sequencer
  import matrix_pkg::*;
#(
  parameter int unsigned N = matrix_pkg::N,
  parameter int unsigned W = matrix_pkg::W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*N*W-1:0] matrix_A,
  input  logic [N*N*W-1:0] matrix_B,
  input  logic             abort,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*N*W-1:0] result_out,
  output logic             overflow,
  output logic [N*N-1:0]   ovf_mask
);

  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(N * N - 1);

  state_e             r_state;
  state_e             w_state_d;
  logic [N*N*W-1:0]   r_a;
  logic [N*N*W-1:0]   r_b;
  logic [CNT_W-1:0]   r_idx;
  logic [N*N*W-1:0]   r_result;
  logic [N*N-1:0]     r_ovf_mask;
  logic [W-1:0]       w_a_elem;
  logic [W-1:0]       w_b_elem;
  logic [W-1:0]       w_diff;
  logic               w_ovf;

  assign w_a_elem = r_a[r_idx*W +: W];
  assign w_b_elem = r_b[r_idx*W +: W];

  elem_subtractor #(
    .W(W)
  ) u_elem_subtractor (
    .i_a   (w_a_elem),
    .i_b   (w_b_elem),
    .o_diff(w_diff),
    .o_ovf (w_ovf)
  );

  // Next-state logic; abort only matters while an operation is in flight.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: if (in_valid) w_state_d = StLoad;
      StLoad: w_state_d = abort ? StIdle : StRun;
      StRun: begin
        if (abort) begin
          w_state_d = StIdle;
        end else if (r_idx == LastIdx) begin
          w_state_d = StDone;
        end
      end
      StDone: if (out_ready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Operand capture, element counter and result/overflow accumulation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_idx      <= '0;
      r_result   <= '0;
      r_ovf_mask <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_a        <= matrix_A;
            r_b        <= matrix_B;
            r_idx      <= '0;
            r_result   <= '0;
            r_ovf_mask <= '0;
          end
        end
        StLoad: begin
          r_idx <= '0;
          if (abort) begin
            r_result   <= '0;
            r_ovf_mask <= '0;
          end
        end
        StRun: begin
          if (abort) begin
            r_idx      <= '0;
            r_result   <= '0;
            r_ovf_mask <= '0;
          end else begin
            r_result[r_idx*W +: W] <= w_diff;
            r_ovf_mask[r_idx]      <= w_ovf;
            r_idx                  <= r_idx + 1'b1;
          end
        end
        StDone: ;
        default: ;
      endcase
    end
  end

  // Handshake and status outputs decoded from the state register.
  always_comb begin
    in_ready   = (r_state == StIdle);
    busy       = (r_state == StLoad) || (r_state == StRun);
    out_valid  = (r_state == StDone);
    result_out = r_result;
    ovf_mask   = r_ovf_mask;
    overflow   = |r_ovf_mask;
  end

endmodule

// File: tb/tb_matrix_sub_sequencer.sv
// Scoreboard bench for matrix_sub_sequencer: expected results are queued at
// handshake time and compared when out_valid appears.
module tb_matrix_sub_sequencer;
  import matrix_pkg::*;

  // Edges from the handshake edge to the first DONE cycle: 1 LOAD + N*N RUN.
  // Counting the handshake edge itself as the first, DONE starts on edge 27.
  localparam int unsigned Latency = 1 + N * N;
  localparam int unsigned Timeout = 200;

  typedef struct packed {
    logic [MAT_W-1:0] res;
    logic [N*N-1:0]   mask;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [MAT_W-1:0] matrix_A;
  logic [MAT_W-1:0] matrix_B;
  logic             abort;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [MAT_W-1:0] result_out;
  logic             overflow;
  logic [N*N-1:0]   ovf_mask;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  matrix_sub_sequencer #(
    .N(N),
    .W(W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .matrix_A  (matrix_A),
    .matrix_B  (matrix_B),
    .abort     (abort),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result_out(result_out),
    .overflow  (overflow),
    .ovf_mask  (ovf_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [MAT_W-1:0] obs,
                          input logic [MAT_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [MAT_W-1:0] fill(input logic [W-1:0] v);
    logic [MAT_W-1:0] m;
    for (int k = 0; k < N * N; k++) m[k*W +: W] = v;
    return m;
  endfunction

  // Reference model: per-element wrapping subtract and signed overflow.
  function automatic exp_t model(input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b);
    exp_t e;
    logic [W-1:0] ea, eb, d;
    for (int k = 0; k < N * N; k++) begin
      ea = a[k*W +: W];
      eb = b[k*W +: W];
      d  = ea - eb;
      e.res[k*W +: W] = d;
      e.mask[k] = (ea[W-1] ^ eb[W-1]) & (d[W-1] ^ ea[W-1]);
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer an operand pair; returns just after the handshake edge.
  task automatic start_op(input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b);
    int waited = 0;
    while (!in_ready && waited < Timeout) begin
      tick();
      waited++;
    end
    check_eq("in_ready_before_start", MAT_W'(in_ready), MAT_W'(1));
    matrix_A = a;
    matrix_B = b;
    in_valid = 1'b1;
    exp_q.push_back(model(a, b));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < Timeout) begin
      tick();
      cycles++;
    end
    if (!out_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_done: out_valid not seen within %0d cycles", Timeout);
    end
  endtask

  // Pop the scoreboard, compare the held result, then release it.
  task automatic finish_op(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = exp_q.pop_front();
    check_eq({tag, "_result"}, result_out, e.res);
    check_eq({tag, "_mask"}, MAT_W'(ovf_mask), MAT_W'(e.mask));
    check_eq({tag, "_overflow"}, MAT_W'(overflow), MAT_W'(|e.mask));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq({tag, "_idle_out_valid"}, MAT_W'(out_valid), MAT_W'(0));
    check_eq({tag, "_idle_in_ready"}, MAT_W'(in_ready), MAT_W'(1));
    check_eq({tag, "_idle_hold"}, result_out, e.res);
  endtask

  task automatic check_idle_clear(input string tag);
    check_eq({tag, "_in_ready"}, MAT_W'(in_ready), MAT_W'(1));
    check_eq({tag, "_busy"}, MAT_W'(busy), MAT_W'(0));
    check_eq({tag, "_out_valid"}, MAT_W'(out_valid), MAT_W'(0));
    check_eq({tag, "_result"}, result_out, '0);
    check_eq({tag, "_mask"}, MAT_W'(ovf_mask), '0);
    check_eq({tag, "_overflow"}, MAT_W'(overflow), '0);
  endtask

  initial begin
    int cycles;
    logic [MAT_W-1:0] a_mix, b_mix, snap;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b0;
    matrix_A  = '0;
    matrix_B  = '0;
    tick();
    tick();
    rst_n = 1'b1;
    check_idle_clear("reset");

    // Basic positive case plus latency.
    start_op(fill(8'd10), fill(8'd3));
    check_eq("busy_in_load", MAT_W'(busy), MAT_W'(1));
    wait_done(cycles);
    check_eq("latency", MAT_W'(cycles), MAT_W'(Latency));
    check_eq("basic_literal", result_out, fill(8'h07));
    finish_op("basic");

    start_op(fill(8'hFB), fill(8'hFF));
    wait_done(cycles);
    check_eq("neg_literal", result_out, fill(8'hFC));
    finish_op("neg");

    start_op(fill(8'h7F), fill(8'h80));
    wait_done(cycles);
    check_eq("ovf_all_mask", MAT_W'(ovf_mask), MAT_W'(25'h1FFFFFF));
    finish_op("ovf_all");

    a_mix = fill(8'd10);
    b_mix = fill(8'd3);
    a_mix[24*W +: W] = 8'h80;
    b_mix[24*W +: W] = 8'h01;
    start_op(a_mix, b_mix);
    wait_done(cycles);
    check_eq("ovf_one_elem", MAT_W'(result_out[24*W +: W]), MAT_W'(8'h7F));
    check_eq("ovf_one_mask", MAT_W'(ovf_mask), MAT_W'(25'h1000000));
    finish_op("ovf_one");

    // Backpressure: result held, new offers ignored.
    start_op(fill(8'd20), fill(8'd50));
    wait_done(cycles);
    snap = result_out;
    matrix_A = fill(8'd1);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("hold_valid", MAT_W'(out_valid), MAT_W'(1));
      check_eq("hold_result", result_out, snap);
      check_eq("hold_in_ready", MAT_W'(in_ready), MAT_W'(0));
    end
    in_valid = 1'b0;
    finish_op("hold");

    // Abort while element 12 is being processed.
    start_op(fill(8'd9), fill(8'd4));
    repeat (13) tick();
    check_eq("abort_busy", MAT_W'(busy), MAT_W'(1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    void'(exp_q.pop_back());
    check_idle_clear("abort");
    start_op(fill(8'd100), fill(8'd33));
    wait_done(cycles);
    finish_op("after_abort");

    // Reset while element 12 is being processed.
    start_op(fill(8'h7F), fill(8'h80));
    repeat (13) tick();
    rst_n = 1'b0;
    abort = 1'b1;
    tick();
    rst_n = 1'b1;
    abort = 1'b0;
    void'(exp_q.pop_back());
    check_idle_clear("midrun_reset");
    start_op(fill(8'hF0), fill(8'h0F));
    wait_done(cycles);
    finish_op("after_reset");

    // Input bus changes during RUN must not reach the result.
    start_op(fill(8'd55), fill(8'd11));
    repeat (5) tick();
    matrix_A = '0;
    matrix_B = fill(8'd99);
    wait_done(cycles);
    finish_op("bus_change");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
